// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: address width, reset vector and the buffered instruction entry.
package fetch_pkg;

   localparam int              XLEN     = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam int              INSTR_W  = 32;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; the head is visible the cycle after it is written (no bypass).
// A push is accepted when full only together with a pop; flush has priority over push and pop.
module sync_fifo import fetch_pkg::*; #(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  T                           push_dat_i,
   input  logic                       pop_i,
   output T                           pop_dat_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign do_pop    = pop_i && !empty_o;
   assign do_push   = push_i && (!full || do_pop);
   assign pop_dat_o = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned requests, buffers in-order responses, squashes on redirect.
// Request issue is throttled so in-flight requests plus buffered entries never exceed DEPTH.
module fetch_unit #(
   parameter int                  XLEN     = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0]     RESET_PC = fetch_pkg::RESET_PC,
   parameter int                  DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [XLEN-1:0]        imem_req_addr,
   input  logic                   imem_resp_valid,
   input  logic [31:0]            imem_resp_data,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic                   if_valid,
   input  logic                   if_ready,
   output logic [XLEN-1:0]        if_pc,
   output logic [31:0]            if_instr
);
   import fetch_pkg::*;

   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = CW + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   buf_count;
   logic [SW-1:0]   in_use;
   logic [XLEN-1:0] redir_aligned;
   logic            buf_empty;
   logic            req_fire;
   logic            resp_keep;
   logic            if_fire;
   fetch_entry_t    push_dat;
   fetch_entry_t    head;

   assign redir_aligned  = redirect_pc & ~XLEN'(3);
   assign in_use         = SW'(outst_q) + SW'(buf_count);
   assign imem_req_valid = !reset && !redirect_valid && (in_use < SW'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   // Responses still owed to a squashed path, or racing a redirect, never reach the buffer.
   assign resp_keep      = imem_resp_valid && !redirect_valid && (discard_q == '0);
   assign if_valid       = !reset && !buf_empty;
   assign if_fire        = if_valid && if_ready;
   assign if_pc          = head.pc;
   assign if_instr       = head.instr;
   assign push_dat       = '{pc: resp_pc_q, instr: imem_resp_data};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      discard_d  = discard_q;
      if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_keep) resp_pc_d  = resp_pc_q + XLEN'(4);
      if (imem_resp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (redirect_valid) begin
         fetch_pc_d = redir_aligned;
         resp_pc_d  = redir_aligned;
         discard_d  = outst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_ibuf (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (redirect_valid),
      .push_i     (resp_keep),
      .push_dat_i (push_dat),
      .pop_i      (if_fire),
      .pop_dat_o  (head),
      .empty_o    (buf_empty),
      .count_o    (buf_count)
   );

endmodule
